// File: rtl/stage_wb_trap.sv
// rtl/stage_wb_trap.sv - write-back stage with trap/MRET flush and fetch redirect
module stage_wb_trap #(
  parameter int XLEN         = 32,
  parameter int NUM_IRQ      = 12,
  parameter int FLUSH_CYCLES = 2,
  parameter int VECTORED     = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [31:0]        instruction_i,
  input  logic [XLEN-1:0]    alu_d_i,
  input  logic [XLEN-1:0]    mem_d_i,
  input  logic [XLEN-1:0]    csr_d_i,
  input  logic [XLEN-1:0]    mem_addr_i,
  input  logic [3:0]         exc_i,
  input  logic               is_mret_i,
  input  logic [XLEN-1:0]    mepc_i,
  input  logic [XLEN-1:0]    mtvec_i,
  input  logic               mie_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  output logic [4:0]         rd_o,
  output logic [XLEN-1:0]    rf_wd_o,
  output logic               we_rf_o,
  output logic               trap_o,
  output logic [XLEN-1:0]    mcause_o,
  output logic [XLEN-1:0]    mepc_o,
  output logic [XLEN-1:0]    mtval_o,
  output logic               flush_o,
  output logic               redirect_o,
  output logic [XLEN-1:0]    redirect_pc_o
);

  localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  state_t            r_state;
  logic              r_ready;
  logic [3:0]        r_flush_cnt;
  logic              r_is_mret;
  logic              r_is_irq;
  logic [CW-1:0]     r_code;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_wd;
  logic              r_we;
  logic              r_trap;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mtval;
  logic              r_flush;
  logic              r_redirect;
  logic [XLEN-1:0]   r_redirect_pc;

  logic [NUM_IRQ-1:0] w_irq_pend;
  logic               w_irq_hit;
  logic [CW-1:0]      w_irq_code;
  logic               w_exc_hit;
  logic [2:0]         w_exc_code;
  logic [XLEN-1:0]    w_exc_tval;
  logic               w_trap;
  logic               w_accept;
  logic               w_wb_en;
  logic [XLEN-1:0]    w_wb_data;
  logic [XLEN-1:0]    w_base;
  logic [XLEN-1:0]    w_redirect_target;
  logic [6:0]         w_opcode;
  logic [4:0]         w_rd;

  assign w_irq_pend = irq_i & irq_en_i;
  assign w_irq_hit  = mie_i && (|w_irq_pend);
  assign w_exc_hit  = |exc_i;
  assign w_trap     = w_irq_hit || w_exc_hit;
  assign w_accept   = valid_i && r_ready;
  assign w_opcode   = instruction_i[6:0];
  assign w_rd       = instruction_i[11:7];
  assign w_base     = {mtvec_i[XLEN-1:2], 2'b00};

  // Highest pending enabled line wins: later loop iterations override earlier ones
  always_comb begin
    w_irq_code = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_irq_pend[i]) w_irq_code = CW'(i);
    end
  end

  // Exception priority: illegal, then instruction misaligned, load, store
  always_comb begin
    w_exc_code = 3'd0;
    w_exc_tval = '0;
    if (exc_i[0]) begin
      w_exc_code = 3'd2;
      w_exc_tval = XLEN'(instruction_i);
    end else if (exc_i[1]) begin
      w_exc_code = 3'd0;
      w_exc_tval = XLEN'(instruction_i);
    end else if (exc_i[2]) begin
      w_exc_code = 3'd4;
      w_exc_tval = mem_addr_i;
    end else if (exc_i[3]) begin
      w_exc_code = 3'd6;
      w_exc_tval = mem_addr_i;
    end
  end

  // Select RF write-back source from the opcode; x0 writes are suppressed
  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_data = '0;
    case (w_opcode)
      7'b0110011, 7'b0010011: begin
        w_wb_en   = 1'b1;
        w_wb_data = alu_d_i;
      end
      7'b0000011: begin
        w_wb_en   = 1'b1;
        w_wb_data = mem_d_i;
      end
      7'b1110011: begin
        w_wb_en   = (instruction_i[14:12] != 3'b000);
        w_wb_data = csr_d_i;
      end
      7'b1101111, 7'b1100111: begin
        w_wb_en   = 1'b1;
        w_wb_data = pc_i + XLEN'(4);
      end
      default: begin
        w_wb_en   = 1'b0;
        w_wb_data = '0;
      end
    endcase
    if (w_rd == 5'd0) w_wb_en = 1'b0;
  end

  // Fetch target at the end of the flush, using the CSR values current at that point
  always_comb begin
    if (r_is_mret) begin
      w_redirect_target = mepc_i;
    end else if (r_is_irq && (VECTORED != 0)) begin
      w_redirect_target = w_base + (XLEN'(r_code) << 2);
    end else begin
      w_redirect_target = w_base;
    end
  end

  // Control FSM: retire or capture a trap in IDLE, hold flush, then pulse redirect
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_flush_cnt   <= '0;
      r_is_mret     <= 1'b0;
      r_is_irq      <= 1'b0;
      r_code        <= '0;
      r_rd          <= '0;
      r_wd          <= '0;
      r_we          <= 1'b0;
      r_trap        <= 1'b0;
      r_mcause      <= '0;
      r_mepc        <= '0;
      r_mtval       <= '0;
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_we          <= 1'b0;
      r_rd          <= '0;
      r_wd          <= '0;
      r_trap        <= 1'b0;
      r_mcause      <= '0;
      r_mepc        <= '0;
      r_mtval       <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_trap || is_mret_i) begin
              r_state     <= S_FLUSH;
              r_ready     <= 1'b0;
              r_flush     <= 1'b1;
              r_flush_cnt <= 4'(FLUSH_CYCLES - 1);
              r_is_mret   <= !w_trap;
              r_is_irq    <= w_irq_hit;
              r_code      <= w_irq_code;
              r_trap      <= w_trap;
              if (w_trap) begin
                r_mepc <= pc_i;
                if (w_irq_hit) begin
                  r_mcause <= {1'b1, (XLEN-1)'(w_irq_code)};
                  r_mtval  <= '0;
                end else begin
                  r_mcause <= XLEN'(w_exc_code);
                  r_mtval  <= w_exc_tval;
                end
              end
            end else if (w_wb_en) begin
              r_we <= 1'b1;
              r_rd <= w_rd;
              r_wd <= w_wb_data;
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state       <= S_REDIRECT;
            r_flush       <= 1'b0;
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_redirect_target;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        S_REDIRECT: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o       = r_ready;
  assign rd_o          = r_rd;
  assign rf_wd_o       = r_wd;
  assign we_rf_o       = r_we;
  assign trap_o        = r_trap;
  assign mcause_o      = r_mcause;
  assign mepc_o        = r_mepc;
  assign mtval_o       = r_mtval;
  assign flush_o       = r_flush;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_stage_wb_trap.sv
// tb/tb_stage_wb_trap.sv - directed and random bench for stage_wb_trap
module tb_stage_wb_trap;

  localparam int XLEN = 32;
  localparam int NIRQ = 12;
  localparam int FC   = 2;
  localparam int VEC  = 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  logic [31:0]     pc_i;
  logic [31:0]     instruction_i;
  logic [31:0]     alu_d_i;
  logic [31:0]     mem_d_i;
  logic [31:0]     csr_d_i;
  logic [31:0]     mem_addr_i;
  logic [3:0]      exc_i;
  logic            is_mret_i;
  logic [31:0]     mepc_i;
  logic [31:0]     mtvec_i;
  logic            mie_i;
  logic [NIRQ-1:0] irq_i;
  logic [NIRQ-1:0] irq_en_i;
  logic [4:0]      rd_o;
  logic [31:0]     rf_wd_o;
  logic            we_rf_o;
  logic            trap_o;
  logic [31:0]     mcause_o;
  logic [31:0]     mepc_o;
  logic [31:0]     mtval_o;
  logic            flush_o;
  logic            redirect_o;
  logic [31:0]     redirect_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  stage_wb_trap #(.XLEN(XLEN), .NUM_IRQ(NIRQ), .FLUSH_CYCLES(FC), .VECTORED(VEC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .instruction_i(instruction_i), .alu_d_i(alu_d_i), .mem_d_i(mem_d_i),
    .csr_d_i(csr_d_i), .mem_addr_i(mem_addr_i), .exc_i(exc_i), .is_mret_i(is_mret_i),
    .mepc_i(mepc_i), .mtvec_i(mtvec_i), .mie_i(mie_i), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .rd_o(rd_o), .rf_wd_o(rf_wd_o), .we_rf_o(we_rf_o), .trap_o(trap_o),
    .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: kind 0 = retire, 1 = trap, 2 = mret
  task automatic model(output int kind, output bit we, output logic [4:0] rd,
                       output logic [31:0] wd, output logic [31:0] cause,
                       output logic [31:0] tval, output logic [31:0] rpc);
    logic [NIRQ-1:0] m;
    logic [31:0]     base;
    int              code;
    m    = irq_i & irq_en_i;
    base = mtvec_i & ~32'h3;
    kind = 0; we = 0; rd = 0; wd = 0; cause = 0; tval = 0; rpc = 0; code = 0;
    if (mie_i && m != 0) begin
      for (int i = NIRQ - 1; i >= 0; i--) begin
        if (m[i]) begin
          code = i;
          break;
        end
      end
      kind  = 1;
      cause = 32'h8000_0000 | 32'(code);
      rpc   = (VEC != 0) ? base + 32'(4 * code) : base;
    end else if (exc_i != 0) begin
      kind = 1;
      rpc  = base;
      if (exc_i[0])      begin cause = 2; tval = instruction_i; end
      else if (exc_i[1]) begin cause = 0; tval = instruction_i; end
      else if (exc_i[2]) begin cause = 4; tval = mem_addr_i; end
      else               begin cause = 6; tval = mem_addr_i; end
    end else if (is_mret_i) begin
      kind = 2;
      rpc  = mepc_i;
    end else begin
      rd = instruction_i[11:7];
      case (instruction_i[6:0])
        7'h33, 7'h13: begin we = 1; wd = alu_d_i; end
        7'h03:        begin we = 1; wd = mem_d_i; end
        7'h73:        begin we = (instruction_i[14:12] != 0); wd = csr_d_i; end
        7'h6F, 7'h67: begin we = 1; wd = pc_i + 32'd4; end
        default:      we = 0;
      endcase
      if (rd == 0) we = 0;
    end
  endtask

  task automatic run_instr(input bit mid_irq);
    int          kind;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] wd, cause, tval, rpc, pc_saved;
    model(kind, we, rd, wd, cause, tval, rpc);
    pc_saved = pc_i;
    chk("ready_pre", 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    if (kind == 0) begin
      chk("we_rf", 64'(we_rf_o), 64'(we));
      if (we) begin
        chk("rd", 64'(rd_o), 64'(rd));
        chk("rf_wd", 64'(rf_wd_o), 64'(wd));
      end
      chk("trap_retire", 64'(trap_o), 64'd0);
      chk("flush_retire", 64'(flush_o), 64'd0);
      chk("ready_retire", 64'(ready_o), 64'd1);
    end else begin
      chk("trap_pulse", 64'(trap_o), 64'(kind == 1));
      if (kind == 1) begin
        chk("mcause", 64'(mcause_o), 64'(cause));
        chk("mepc", 64'(mepc_o), 64'(pc_saved));
        chk("mtval", 64'(mtval_o), 64'(tval));
      end
      chk("flush_first", 64'(flush_o), 64'd1);
      chk("we_on_trap", 64'(we_rf_o), 64'd0);
      chk("ready_busy", 64'(ready_o), 64'd0);
      chk("redir_early", 64'(redirect_o), 64'd0);
      if (mid_irq) begin
        mie_i    = 1'b1;
        irq_i    = 12'h008;
        irq_en_i = 12'h008;
      end
      for (int k = 1; k < FC; k++) begin
        tick();
        chk("flush_hold", 64'(flush_o), 64'd1);
        chk("redir_hold", 64'(redirect_o), 64'd0);
        chk("trap_hold", 64'(trap_o), 64'd0);
      end
      tick();
      chk("redirect", 64'(redirect_o), 64'd1);
      chk("redirect_pc", 64'(redirect_pc_o), 64'(rpc));
      chk("flush_off", 64'(flush_o), 64'd0);
      chk("trap_redir", 64'(trap_o), 64'd0);
      chk("we_redir", 64'(we_rf_o), 64'd0);
      tick();
      chk("redirect_end", 64'(redirect_o), 64'd0);
      chk("ready_back", 64'(ready_o), 64'd1);
    end
  endtask

  task automatic clear_inputs();
    valid_i = 0; pc_i = 0; instruction_i = 32'h13; alu_d_i = 0; mem_d_i = 0;
    csr_d_i = 0; mem_addr_i = 0; exc_i = 0; is_mret_i = 0; mepc_i = 0;
    mtvec_i = 0; mie_i = 0; irq_i = 0; irq_en_i = 0;
  endtask

  initial begin
    logic [6:0] op;
    clear_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_we", 64'(we_rf_o), 64'd0);
    chk("rst_trap", 64'(trap_o), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_redirect", 64'(redirect_o), 64'd0);
    chk("rst_rpc", 64'(redirect_pc_o), 64'd0);
    chk("rst_mcause", 64'(mcause_o), 64'd0);
    rst_i = 1'b1;
    tick();

    // ALU retire
    instruction_i = 32'h00A00093; alu_d_i = 32'h1234;
    run_instr(0);
    // JAL wrap, then rd=0
    instruction_i = 32'h0000006F | (32'd5 << 7); pc_i = 32'hFFFFFFFC;
    run_instr(0);
    instruction_i = 32'h0000006F;
    run_instr(0);
    // illegal + ld_mis
    instruction_i = 32'hDEADBEEF; pc_i = 32'h80; exc_i = 4'b0101;
    mem_addr_i = 32'h55; mtvec_i = 32'h103;
    run_instr(0);
    // interrupt beats exception
    exc_i = 4'b0010; mie_i = 1; irq_i = 12'h880; irq_en_i = 12'h880; mtvec_i = 32'h100;
    run_instr(0);
    // MRET with irq raised during flush
    clear_inputs();
    mtvec_i = 32'h400; is_mret_i = 1; mepc_i = 32'h200;
    run_instr(1);
    is_mret_i = 0; instruction_i = 32'h00A00093;
    run_instr(0);
    clear_inputs();
    tick();
    chk("idle_we", 64'(we_rf_o), 64'd0);

    // reset during FLUSH
    exc_i = 4'b0001; mtvec_i = 32'h300; valid_i = 1;
    tick();
    valid_i = 0;
    chk("pre_rst_trap", 64'(trap_o), 64'd1);
    rst_i = 1'b0;
    tick();
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_flush", 64'(flush_o), 64'd0);
    chk("mid_rst_redir", 64'(redirect_o), 64'd0);
    chk("mid_rst_trap", 64'(trap_o), 64'd0);
    chk("mid_rst_rpc", 64'(redirect_pc_o), 64'd0);
    rst_i = 1'b1;
    exc_i = 0;
    for (int k = 0; k < FC + 2; k++) begin
      tick();
      chk("post_rst_redir", 64'(redirect_o), 64'd0);
      chk("post_rst_ready", 64'(ready_o), 64'd1);
    end

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      clear_inputs();
      if ($urandom_range(0, 4) == 0) begin
        instruction_i = 32'h00A00093;
        tick();
        chk("noacc_we", 64'(we_rf_o), 64'd0);
        chk("noacc_trap", 64'(trap_o), 64'd0);
        chk("noacc_ready", 64'(ready_o), 64'd1);
      end else begin
        pc_i = $urandom; alu_d_i = $urandom; mem_d_i = $urandom; csr_d_i = $urandom;
        mem_addr_i = $urandom; mepc_i = $urandom; mtvec_i = $urandom;
        case ($urandom_range(0, 6))
          0: op = 7'h33;
          1: op = 7'h13;
          2: op = 7'h03;
          3: op = 7'h73;
          4: op = 7'h6F;
          5: op = 7'h67;
          default: op = 7'($urandom);
        endcase
        instruction_i = {$urandom} & 32'hFFFF_FF80;
        instruction_i = instruction_i | 32'(op);
        exc_i     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        is_mret_i = ($urandom_range(0, 7) == 0);
        mie_i     = 1'($urandom_range(0, 1));
        irq_i     = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'd0;
        irq_en_i  = 12'($urandom);
        run_instr(0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
